// File: rtl/z80_io_capture.sv
// z80_io_capture: Z80 I/O bus snooper.
// It synchronises the raw bus and times each IORQ read/write strobe.
// Address and data are sampled at a fixed or self-measured point inside the strobe.
// The port address is classified against NUM_CH match channels, and hits are queued in an event FIFO.
module z80_io_capture #(
    parameter int SAMPLE_MODE = 1,
    parameter int SAMPLE_DLY  = 8,
    parameter int MIN_LEN     = 3,
    parameter int NUM_CH      = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 z80_iorq_n,
    input  logic                 z80_wr_n,
    input  logic                 z80_rd_n,
    input  logic                 z80_m1_n,
    input  logic [15:0]          z80_addr,
    input  logic [7:0]           z80_data,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic [16*NUM_CH-1:0] ch_base,
    input  logic [16*NUM_CH-1:0] ch_mask,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [15:0]          evt_addr,
    output logic [7:0]           evt_data,
    output logic                 evt_dir,
    output logic [2:0]           evt_ch,
    output logic [7:0]           evt_len,
    output logic                 overflow,
    input  logic                 ovf_clr,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_END    = 2'd2;

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
    localparam logic [7:0]    MIN_LEN_C    = 8'(MIN_LEN);
    localparam logic [7:0]    SAMPLE_DLY_C = 8'(SAMPLE_DLY);

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        dir;
        logic [2:0]  ch;
        logic [7:0]  len;
    } evt_t;

    // Synchroniser stages; strobe bit order is {iorq_n, wr_n, rd_n, m1_n}.
    logic [3:0]  strb_meta_q, strb_sync_q;
    logic [15:0] addr_meta_q, addr_sync_q;
    logic [7:0]  data_meta_q, data_sync_q;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  sample_pt_q, sample_pt_d;
    logic        dir_q, dir_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        rearm_q, rearm_d;

    logic iorq_s, wr_s, rd_s, m1_s;
    logic wr_act, rd_act, cyc_act;
    logic [7:0] cnt_inc;

    logic       hit;
    logic [2:0] hit_ch;

    evt_t          mem_q [FIFO_DEPTH];
    evt_t          head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_req, push_ok, pop, full, drop;

    // Two-flop synchronisers for every raw bus input; strobes reset to the inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_meta_q <= 4'hF;
            strb_sync_q <= 4'hF;
            addr_meta_q <= '0;
            addr_sync_q <= '0;
            data_meta_q <= '0;
            data_sync_q <= '0;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
            strb_meta_q <= {z80_iorq_n, z80_wr_n, z80_rd_n, z80_m1_n};
            strb_sync_q <= strb_meta_q;
            addr_meta_q <= z80_addr;
            addr_sync_q <= addr_meta_q;
            data_meta_q <= z80_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign {iorq_s, wr_s, rd_s, m1_s} = strb_sync_q;
    assign wr_act  = !iorq_s && m1_s && !wr_s && rd_s;
    assign rd_act  = !iorq_s && m1_s && wr_s && !rd_s;
    assign cyc_act = wr_act || rd_act;
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Cycle FSM: time the strobe, track the sample window, and adapt the sample point.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        sample_pt_d = sample_pt_q;
        dir_d       = dir_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rearm_d     = rearm_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_s && rd_s) rearm_d = 1'b1;
                if (cyc_act && rearm_q) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = 8'd1;
                    dir_d   = wr_act;
                    addr_d  = addr_sync_q;
                    data_d  = data_sync_q;
                    rearm_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (cyc_act && (wr_act == dir_q)) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc <= sample_pt_q) begin
                        addr_d = addr_sync_q;
                        data_d = data_sync_q;
                    end
                end else begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
                if ((SAMPLE_MODE == 1) && (cnt_q >= MIN_LEN_C))
                    sample_pt_d = ((cnt_q >> 1) == 8'd0) ? 8'd1 : (cnt_q >> 1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sample_pt_q <= SAMPLE_DLY_C;
            dir_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rearm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sample_pt_q <= sample_pt_d;
            dir_q       <= dir_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rearm_q     <= rearm_d;
        end
    end

    // Channel match; scanning downward lets the lowest matching channel win.
    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_en[k] && ((addr_q & ch_mask[16*k +: 16]) ==
                             (ch_base[16*k +: 16] & ch_mask[16*k +: 16]))) begin
                hit    = 1'b1;
                hit_ch = 3'(k);
            end
        end
    end

    assign full     = (count_q == DEPTH_C);
    assign pop      = evt_valid && evt_ready;
    assign push_req = (state_q == ST_END) && (cnt_q >= MIN_LEN_C) && hit;
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // FIFO storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the outputs are gated by evt_valid, so stale entries never leak.
        if (push_ok) mem_q[wr_ptr_q] <= '{addr: addr_q, data: data_q, dir: dir_q, ch: hit_ch, len: cnt_q};
    end

    // FIFO pointers, occupancy, and the sticky overflow flag (a set wins over a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // Head-of-queue presentation, held at zero while the FIFO is empty.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        evt_valid = (count_q != '0);
        evt_addr  = evt_valid ? head.addr : 16'h0000;
        evt_data  = evt_valid ? head.data : 8'h00;
        evt_dir   = evt_valid ? head.dir  : 1'b0;
        evt_ch    = evt_valid ? head.ch   : 3'd0;
        evt_len   = evt_valid ? head.len  : 8'h00;
        busy      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_z80_io_capture.sv
// tb_z80_io_capture: table-driven vectors, hand-written corner sequences and a
// randomized phase for z80_io_capture, checked against a behavioural event model.
module tb_z80_io_capture;

    localparam int MIN_LEN = 3;
    localparam int DEPTH   = 4;
    localparam int SP0     = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        z80_iorq_n = 1'b1, z80_wr_n = 1'b1, z80_rd_n = 1'b1, z80_m1_n = 1'b1;
    logic [15:0] z80_addr = '0;
    logic [7:0]  z80_data = '0;
    logic [3:0]  ch_en = '0;
    logic [63:0] ch_base, ch_mask;
    logic        evt_valid, evt_ready = 1'b0;
    logic [15:0] evt_addr;
    logic [7:0]  evt_data;
    logic        evt_dir;
    logic [2:0]  evt_ch;
    logic [7:0]  evt_len;
    logic        overflow, ovf_clr = 1'b0, busy;

    logic [15:0] base_a [4] = '{16'h00F0, 16'h0070, 16'h1200, 16'h0070};
    logic [15:0] mask_a [4] = '{16'hFFF0, 16'hFFFF, 16'hFF00, 16'h00F0};
    assign ch_base = {base_a[3], base_a[2], base_a[1], base_a[0]};
    assign ch_mask = {mask_a[3], mask_a[2], mask_a[1], mask_a[0]};

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        dir;
        logic [2:0]  ch;
        logic [7:0]  len;
    } evt_t;

    typedef struct {
        logic        dir;
        logic [15:0] addr;
        logic [7:0]  d0, d1;
        int          chg, len;
        logic        m1;
        logic [3:0]  en;
        bit          hit;
        logic [2:0]  ech;
        logic [7:0]  edata;
        logic [7:0]  elen;
    } vec_t;

    evt_t exp_q[$];
    int   n_vec = 0, n_bad = 0;
    int   sp_m = SP0;
    bit   ovf_m = 1'b0;

    logic [36:0] dut_rec;
    assign dut_rec = {evt_valid, evt_addr, evt_data, evt_dir, evt_ch, evt_len};

    z80_io_capture #(
        .SAMPLE_MODE(1), .SAMPLE_DLY(SP0), .MIN_LEN(MIN_LEN), .NUM_CH(4), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .z80_iorq_n(z80_iorq_n), .z80_wr_n(z80_wr_n), .z80_rd_n(z80_rd_n), .z80_m1_n(z80_m1_n),
        .z80_addr(z80_addr), .z80_data(z80_data),
        .ch_en(ch_en), .ch_base(ch_base), .ch_mask(ch_mask),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_addr(evt_addr), .evt_data(evt_data), .evt_dir(evt_dir), .evt_ch(evt_ch), .evt_len(evt_len),
        .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model of one bus cycle, expressed as event-level outcomes.
    function automatic void model_cycle(input logic dir, input logic [15:0] addr,
                                        input logic [7:0] d0, input logic [7:0] d1,
                                        input int chg, input int len, input logic m1,
                                        input logic [3:0] en, input int at_push);
        evt_t e;
        int   idx, lsat, ch;
        if (at_push == 1 && exp_q.size() > 0) void'(exp_q.pop_front());
        if (at_push == 2) ovf_m = 1'b0;
        if (!m1 || len < MIN_LEN) return;
        idx  = ((len < sp_m) ? len : sp_m) - 1;
        lsat = (len > 255) ? 255 : len;
        sp_m = (lsat / 2 < 1) ? 1 : lsat / 2;
        ch = -1;
        for (int k = 3; k >= 0; k--)
            if (en[k] && ((addr & mask_a[k]) == (base_a[k] & mask_a[k]))) ch = k;
        if (ch < 0) return;
        e.addr = addr;
        e.data = (idx >= chg) ? d1 : d0;
        e.dir  = dir;
        e.ch   = 3'(ch);
        e.len  = 8'(lsat);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else ovf_m = 1'b1;
    endfunction

    // Drive one strobe: low for 'len' clock edges, data switches to d1 from edge 'chg'.
    // at_push: 1 = pop, 2 = ovf_clr, asserted for exactly the push edge.
    task automatic run_cycle(input logic dir, input logic [15:0] addr, input logic [7:0] d0,
                             input logic [7:0] d1, input int chg, input int len, input logic m1,
                             input logic [3:0] en, input int at_push);
        model_cycle(dir, addr, d0, d1, chg, len, m1, en, at_push);
        ch_en = en;
        @(negedge clk);
        z80_addr   = addr;
        z80_data   = (chg == 0) ? d1 : d0;
        z80_iorq_n = 1'b0;
        z80_m1_n   = m1;
        z80_wr_n   = ~dir;
        z80_rd_n   = dir;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == chg) z80_data = d1;
        end
        z80_iorq_n = 1'b1; z80_wr_n = 1'b1; z80_rd_n = 1'b1; z80_m1_n = 1'b1;
        repeat (3) @(negedge clk);
        if (at_push == 1) evt_ready = 1'b1;
        if (at_push == 2) ovf_clr = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        evt_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_evt"}, 64'(dut_rec), 64'({1'b1, e}));
            pop_one();
        end
        check({tag, "_empty"}, 64'(evt_valid), 64'd0);
    endtask

    task automatic clr_ovf();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        ovf_m   = 1'b0;
    endtask

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1, 16'h00F5, 8'h5A, 8'h5A, 1,   20,  1, 4'hF, 1, 3'd0, 8'h5A, 8'd20};
        tbl[1]  = '{1, 16'h00F5, 8'h11, 8'h22, 12,  20,  1, 4'hF, 1, 3'd0, 8'h11, 8'd20};
        tbl[2]  = '{1, 16'h00F6, 8'h33, 8'h44, 5,   16,  1, 4'hF, 1, 3'd0, 8'h44, 8'd16};
        tbl[3]  = '{0, 16'h0070, 8'h01, 8'h01, 1,   2,   1, 4'hF, 0, 3'd0, 8'h00, 8'd0};
        tbl[4]  = '{0, 16'h0070, 8'h01, 8'h01, 1,   10,  0, 4'hF, 0, 3'd0, 8'h00, 8'd0};
        tbl[5]  = '{0, 16'h0070, 8'hA5, 8'hC3, 3,   6,   1, 4'hA, 1, 3'd1, 8'hC3, 8'd6};
        tbl[6]  = '{1, 16'h0070, 8'h01, 8'h01, 1,   8,   1, 4'h0, 0, 3'd0, 8'h00, 8'd0};
        tbl[7]  = '{1, 16'h1234, 8'h01, 8'h02, 4,   10,  1, 4'hF, 1, 3'd2, 8'h01, 8'd10};
        tbl[8]  = '{1, 16'h0171, 8'h77, 8'h88, 2,   3,   1, 4'hF, 1, 3'd3, 8'h88, 8'd3};
        tbl[9]  = '{1, 16'h00FF, 8'h10, 8'h20, 1,   30,  1, 4'hF, 1, 3'd0, 8'h10, 8'd30};
        tbl[10] = '{1, 16'h00F1, 8'h99, 8'h66, 100, 260, 1, 4'hF, 1, 3'd0, 8'h99, 8'd255};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_state", 64'({dut_rec, overflow, busy}), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table vectors, each applied to an empty FIFO.
        for (int i = 0; i < 11; i++) begin
            run_cycle(tbl[i].dir, tbl[i].addr, tbl[i].d0, tbl[i].d1, tbl[i].chg, tbl[i].len,
                      tbl[i].m1, tbl[i].en, 0);
            exp_q.delete();
            if (tbl[i].hit) begin
                check($sformatf("tbl%0d_evt", i), 64'(dut_rec),
                      64'({1'b1, tbl[i].addr, tbl[i].edata, tbl[i].dir, tbl[i].ech, tbl[i].elen}));
                pop_one();
            end
            check($sformatf("tbl%0d_empty", i), 64'(evt_valid), 64'd0);
        end

        // FIFO overflow: five writes into a depth-4 FIFO with no pops.
        for (int i = 0; i < 5; i++)
            run_cycle(1, 16'h00F0 + 16'(i), 8'(i), 8'(i), 1, 4, 1, 4'hF, 0);
        check("ovf_set", 64'(overflow), 64'(ovf_m));
        clr_ovf();
        check("ovf_clr", 64'(overflow), 64'd0);
        run_cycle(1, 16'h00F9, 8'h09, 8'h09, 1, 4, 1, 4'hF, 2);
        check("ovf_set_beats_clr", 64'(overflow), 64'(ovf_m));
        drain("ovf");
        clr_ovf();
        check("ovf_clr2", 64'(overflow), 64'd0);

        // Full FIFO with a pop on the push edge: push accepted, no overflow.
        for (int i = 0; i < 4; i++)
            run_cycle(1, 16'h00F0 + 16'(i), 8'h40 + 8'(i), 8'h40 + 8'(i), 1, 5, 1, 4'hF, 0);
        run_cycle(1, 16'h00F8, 8'h48, 8'h48, 1, 5, 1, 4'hF, 1);
        check("full_pop_ovf", 64'(overflow), 64'd0);
        drain("fullpop");

        // Direction change mid-cycle: one write event, the trailing read is ignored.
        model_cycle(1, 16'h00F7, 8'h3C, 8'h3C, 1, 6, 1, 4'hF, 0);
        ch_en = 4'hF;
        @(negedge clk);
        z80_addr = 16'h00F7; z80_data = 8'h3C;
        z80_iorq_n = 1'b0; z80_m1_n = 1'b1; z80_wr_n = 1'b0; z80_rd_n = 1'b1;
        repeat (6) @(negedge clk);
        z80_wr_n = 1'b1; z80_rd_n = 1'b0;
        repeat (8) @(negedge clk);
        z80_iorq_n = 1'b1; z80_rd_n = 1'b1;
        repeat (8) @(negedge clk);
        drain("dirchg");

        // Reset during ACTIVE with two events queued.
        run_cycle(1, 16'h00F2, 8'hAB, 8'hAB, 1, 20, 1, 4'hF, 0);
        run_cycle(1, 16'h00F3, 8'hAC, 8'hAC, 1, 20, 1, 4'hF, 0);
        check("rst_pre_valid", 64'(evt_valid), 64'd1);
        @(negedge clk);
        z80_addr = 16'h00F3; z80_data = 8'hCD;
        z80_iorq_n = 1'b0; z80_wr_n = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_pre", 64'(busy), 64'd0);
        @(negedge clk);
        check("busy_rise", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(evt_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        z80_iorq_n = 1'b1; z80_wr_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        sp_m  = SP0;
        ovf_m = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_no_partial", 64'({evt_valid, busy, overflow}), 64'd0);
        run_cycle(1, 16'h00F4, 8'h01, 8'h02, 8, 20, 1, 4'hF, 0);
        drain("rst_sp");

        // Randomized phase against the behavioural model.
        for (int i = 0; i < 48; i++) begin
            logic [15:0] a;
            int          len, chg;
            case ($urandom_range(0, 4))
                0: a = 16'h00F5;
                1: a = 16'h0070;
                2: a = 16'h1234;
                3: a = 16'h0171;
                default: a = 16'($urandom);
            endcase
            len = $urandom_range(1, 24);
            chg = $urandom_range(1, len);
            run_cycle(1'($urandom), a, 8'($urandom), 8'($urandom), chg, len,
                      ($urandom_range(0, 7) != 0), 4'($urandom), 0);
            if (i % 6 == 5) begin
                check($sformatf("rnd%0d_ovf", i), 64'(overflow), 64'(ovf_m));
                clr_ovf();
                drain($sformatf("rnd%0d", i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/z80_io_capture.md
# z80_io_capture

Parametrised Z80 I/O bus snooper that succeeds the single-address midpoint sampler. It watches IORQ write and read cycles and samples address and data at a programmable or self-measured point inside each strobe. It classifies the port address against NUM_CH match channels and queues matched events in a FIFO for downstream FujiNet logic. It sits between the raw Z80 bus pins and the device-emulation state machines.

## Interface
- SAMPLE_MODE, 1: 0 = fixed delay SAMPLE_DLY; 1 = midpoint of previous cycle (half its length)
- SAMPLE_DLY, 8: sample point in clk cycles for mode 0, and after reset in mode 1; range 1..255
- MIN_LEN, 3: strobes active fewer clk cycles than this are glitches and are discarded
- NUM_CH, 4: number of address match channels, 1..8
- FIFO_DEPTH, 8: event FIFO depth, power of two, 2..64
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- z80_iorq_n, z80_wr_n, z80_rd_n, z80_m1_n  in  1 each  raw Z80 strobes, asynchronous to clk
- z80_addr  in  16  raw address bus
- z80_data  in  8  raw data bus
- ch_en  in  NUM_CH  per-channel enable
- ch_base, ch_mask  in  16*NUM_CH each  channel k in bits [16k+15:16k]
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  pop when evt_valid & evt_ready
- evt_addr  out  16  head event address
- evt_data  out  8  head event data
- evt_dir  out  1  1 = write, 0 = read
- evt_ch  out  3  matching channel index
- evt_len  out  8  measured strobe length, saturating
- overflow  out  1  sticky; an event was lost to a full FIFO
- ovf_clr  in  1  clears overflow
- busy  out  1  a bus cycle is in progress

## Operation
- All z80_* inputs pass through 2-flop synchronisers before use.
- Active cycle: synced iorq_n=0, m1_n=1, and exactly one of wr_n or rd_n equal to 0. IORQ with M1 low (interrupt acknowledge) is ignored. If wr_n and rd_n are both low, the cycle is ignored.
- FSM states:
  - IDLE -> ACTIVE on an active cycle: cnt=1, dir latched, addr/data captured.
  - ACTIVE: cnt increments, saturating at 255. While cnt <= sample_pt, addr/data are recaptured every cycle; after that they are frozen. Strobe release moves to END.
  - END (1 cycle): if cnt < MIN_LEN, the cycle is discarded. Otherwise the address is matched and the event is pushed if it matches; in mode 1, sample_pt <= max(1, cnt>>1). Then go to IDLE.
- If the strobe ends before sample_pt is reached, the values from the last active cycle are used.
- Channel match: ch_en[k] & ((addr & mask_k) == (base_k & mask_k)). The lowest k wins. With no match, nothing is pushed and sample_pt still updates.
- Discarded glitches do not update sample_pt.
- FIFO:
  - A push when full with no pop that cycle drops the event and sets overflow.
  - A push while full with a simultaneous pop is accepted.
  - overflow set and ovf_clr in the same cycle: overflow stays 1.
- dir change mid-cycle (wr_n to rd_n) ends the current cycle. IDLE must see both strobes high before the next cycle starts.

## Timing
- Reset values: evt_valid 0, all evt_* 0, overflow 0, busy 0, FIFO empty, sample_pt = SAMPLE_DLY, FSM IDLE.
- Synchroniser latency is 2 clk. busy rises 3 clk after the raw strobe falls.
- Push happens in END, 1 clk after the synced strobe release. evt_valid rises the cycle after the push, so an empty FIFO has latency 4 clk from raw release.
- evt_* are stable while evt_valid=1 and no pop occurs. The next entry is presented the cycle after a pop.
- Reset asserted mid-cycle aborts the cycle, empties the FIFO and clears overflow. No partial event survives.

## Test plan
- Mode 1, channel 0 base 0x00F0 mask 0xFFF0; write to port 0x00F5 data 0x5A with 20-clk strobe.
  - Expect: event addr 0x00F5, data 0x5A, dir 1, ch 0, len 20; next sample_pt 10.
  - Second write with data changing at clk 12: the captured data is the value at sample point 10.
- Read with a 2-clk strobe (MIN_LEN 3) -> no event, sample_pt unchanged. Read with M1 low -> ignored.
- Two channels both matching 0x0070 (ch1 and ch3 enabled) -> evt_ch 1. ch_en=0 for all channels -> no event.
- FIFO_DEPTH 4, evt_ready 0, 5 writes:
  - 4 events queued and overflow 1; the 5th event is lost.
  - Pop all four in order, then ovf_clr -> overflow 0.
- Full FIFO with a pop coinciding with a push -> push accepted, count stays 4, overflow stays 0.
- Assert rst_n low during ACTIVE with 2 events queued -> evt_valid 0, busy 0, sample_pt = SAMPLE_DLY on release.
